fetch_unit: RTL

//  Instruction fetch stage directly upstream of the control unit. Holds the PC and

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage, the instruction cache and the decode stage.
// The fetch unit takes the master side; the cache/decode environment takes
// the slave side.
interface fetch_unit_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_npc;
  logic        instr_valid;
  logic        halted;

  modport master (
    output imemREN, imemaddr, instr, instr_pc, instr_npc, instr_valid, halted,
    input  imemload, ihit, stall, redirect, redirect_pc
  );

  modport slave (
    input  imemREN, imemaddr, instr, instr_pc, instr_npc, instr_valid, halted,
    output imemload, ihit, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests instructions from the cache,
// and holds one registered instruction (with its PC and PC+4) for decode.
// Redirects squash the held instruction; a HALT opcode stops fetching and,
// once decode takes it, latches a sticky halted flag.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic         CLK,
  input  logic         nRST,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {FETCH, HALTWAIT, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] instr_pc_q, instr_pc_n;
  logic [31:0] instr_npc_q, instr_npc_n;
  logic        valid_q, valid_n;
  logic        halted_q, halted_n;

  logic        consume;
  logic        full_stalled;
  logic        req;
  logic [31:0] target_pc;
  logic [31:0] pc_plus4;

  // Next-state and request logic; redirect outranks a same-cycle hit or consume
  always_comb begin
    consume      = valid_q & ~bus.stall;
    full_stalled = valid_q & bus.stall;
    req          = (state == FETCH) & ~full_stalled & nRST;
    target_pc    = {bus.redirect_pc[31:2], 2'b00};
    pc_plus4     = pc + 32'd4;

    state_n     = state;
    pc_n        = pc;
    instr_n     = instr_q;
    instr_pc_n  = instr_pc_q;
    instr_npc_n = instr_npc_q;
    valid_n     = valid_q;
    halted_n    = halted_q;

    case (state)
      FETCH: begin
        if (bus.redirect) begin
          pc_n    = target_pc;
          valid_n = 1'b0;
        end else if (req && bus.ihit) begin
          instr_n     = bus.imemload;
          instr_pc_n  = pc;
          instr_npc_n = pc_plus4;
          valid_n     = 1'b1;
          pc_n        = pc_plus4;
          if (bus.imemload[31:26] == HALT_OP) begin
            state_n = HALTWAIT;
          end
        end else if (consume) begin
          valid_n = 1'b0;
        end
      end
      HALTWAIT: begin
        if (bus.redirect) begin
          pc_n    = target_pc;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (consume) begin
          valid_n  = 1'b0;
          halted_n = 1'b1;
          state_n  = DONE;
        end
      end
      default: begin
        state_n = DONE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      instr_q     <= 32'h0;
      instr_pc_q  <= 32'h0;
      instr_npc_q <= 32'h0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_q     <= instr_n;
      instr_pc_q  <= instr_pc_n;
      instr_npc_q <= instr_npc_n;
      valid_q     <= valid_n;
      halted_q    <= halted_n;
    end
  end

  assign bus.imemREN     = req;
  assign bus.imemaddr    = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_npc   = instr_npc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

endmodule
